// File: rtl/eep_pgm_sequencer.sv
// Timing sequencer for one EEPROM cache-word program cycle: clear strobe, program strobe, optional read-back verify.
// Optional verify/retry feature is enabled by defining EEP_VERIFY_EN.
module eep_pgm_sequencer #(
    parameter int CACHE_WIDTH   = 8,
    parameter int CLR_CYCLES    = 20,
    parameter int PGM_CYCLES    = 40,
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_RETRY     = 2
) (
    input  logic                   sys_clk,
    input  logic                   porb,
    input  logic                   pgm_req,
    input  logic [CACHE_WIDTH-1:0] pgm_data,
    input  logic                   timeoutb,
    input  logic [CACHE_WIDTH-1:0] eep_rdata,
    output logic [CACHE_WIDTH-1:0] eep_wdata,
    output logic                   eep_clrb,
    output logic                   pgm_eep,
    output logic                   read_eep,
    output logic                   eep_cycleb,
    output logic                   busy,
    output logic                   done,
    output logic                   fail
);

    localparam int MAX_CS = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
    localparam int MAX_P  = (MAX_CS > PGM_CYCLES) ? MAX_CS : PGM_CYCLES;
    localparam int CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] PGM_LOAD = CNT_W'(PGM_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_SETTLE_C = 3'd2,
        ST_PROGRAM  = 3'd3,
        ST_SETTLE_P = 3'd4,
        ST_DONE     = 3'd5
`ifdef EEP_VERIFY_EN
        , ST_VERIFY = 3'd6
`endif
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;

`ifdef EEP_VERIFY_EN
    localparam int ATT_W = $clog2(MAX_RETRY + 2);
    localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(MAX_RETRY);
    localparam logic [ATT_W-1:0] ATT_ZERO = {ATT_W{1'b0}};
    localparam logic [ATT_W-1:0] ATT_ONE  = {{(ATT_W-1){1'b0}}, 1'b1};
    logic [ATT_W-1:0] attempt_r;
`else
    // Read data and retry limit only matter when verify is built in.
    logic [CACHE_WIDTH:0] unused_s;
    assign unused_s = {eep_rdata, (MAX_RETRY > 0) ? 1'b1 : 1'b0};
`endif

    // Sequencer FSM with all strobes and status flags registered alongside the state.
    always_ff @(posedge sys_clk) begin
        if (!porb) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            eep_wdata  <= {CACHE_WIDTH{1'b0}};
            eep_clrb   <= 1'b1;
            pgm_eep    <= 1'b0;
            read_eep   <= 1'b0;
            eep_cycleb <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
`ifdef EEP_VERIFY_EN
            attempt_r  <= ATT_ZERO;
`endif
        end else begin
            done <= 1'b0;
            // An abort outranks any timed exit; DONE is left alone so its pulse stays one cycle.
            if ((state_r != ST_IDLE) && (state_r != ST_DONE) && !timeoutb) begin
                state_r  <= ST_DONE;
                eep_clrb <= 1'b1;
                pgm_eep  <= 1'b0;
                read_eep <= 1'b0;
                fail     <= 1'b1;
                done     <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (pgm_req && timeoutb) begin
                            state_r    <= ST_CLEAR;
                            cnt_r      <= CLR_LOAD;
                            eep_wdata  <= pgm_data;
                            eep_clrb   <= 1'b0;
                            eep_cycleb <= 1'b0;
                            busy       <= 1'b1;
                            fail       <= 1'b0;
`ifdef EEP_VERIFY_EN
                            attempt_r  <= ATT_ZERO;
`endif
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_CLEAR: begin
                        if (cnt_r == CNT_ZERO) begin
                            state_r  <= ST_SETTLE_C;
                            cnt_r    <= SET_LOAD;
                            eep_clrb <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                    ST_SETTLE_C: begin
                        if (cnt_r == CNT_ZERO) begin
                            state_r <= ST_PROGRAM;
                            cnt_r   <= PGM_LOAD;
                            pgm_eep <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                    ST_PROGRAM: begin
                        if (cnt_r == CNT_ZERO) begin
                            state_r <= ST_SETTLE_P;
                            cnt_r   <= SET_LOAD;
                            pgm_eep <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                    ST_SETTLE_P: begin
                        if (cnt_r == CNT_ZERO) begin
`ifdef EEP_VERIFY_EN
                            state_r  <= ST_VERIFY;
                            cnt_r    <= CNT_ONE;
                            read_eep <= 1'b1;
`else
                            state_r  <= ST_DONE;
                            done     <= 1'b1;
`endif
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
`ifdef EEP_VERIFY_EN
                    // Read data is only trusted on the second read cycle.
                    ST_VERIFY: begin
                        if (cnt_r == CNT_ZERO) begin
                            read_eep <= 1'b0;
                            if (eep_rdata == eep_wdata) begin
                                state_r <= ST_DONE;
                                done    <= 1'b1;
                            end else if (attempt_r < ATT_MAX) begin
                                state_r   <= ST_CLEAR;
                                cnt_r     <= CLR_LOAD;
                                eep_clrb  <= 1'b0;
                                attempt_r <= attempt_r + ATT_ONE;
                            end else begin
                                state_r <= ST_DONE;
                                done    <= 1'b1;
                                fail    <= 1'b1;
                            end
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
`endif
                    ST_DONE: begin
                        state_r    <= ST_IDLE;
                        busy       <= 1'b0;
                        eep_cycleb <= 1'b1;
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        eep_clrb   <= 1'b1;
                        pgm_eep    <= 1'b0;
                        read_eep   <= 1'b0;
                        busy       <= 1'b0;
                        eep_cycleb <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eep_pgm_sequencer.sv
// Self-checking bench for eep_pgm_sequencer: directed scenarios plus random stimulus against a timeline model.
module tb_eep_pgm_sequencer;

    localparam int CW   = 8;
    localparam int CLR  = 20;
    localparam int PGM  = 40;
    localparam int S    = 4;
    localparam int MAXR = 2;
    localparam int T_SP_END = CLR + 2*S + PGM;
`ifdef EEP_VERIFY_EN
    localparam int T_CMP  = T_SP_END + 1;
    localparam int T_DONE = T_SP_END + 2;
`else
    localparam int T_DONE = T_SP_END;
`endif

    logic          sys_clk = 1'b0;
    logic          porb = 1'b0;
    logic          pgm_req = 1'b0;
    logic [CW-1:0] pgm_data = '0;
    logic          timeoutb = 1'b1;
    logic [CW-1:0] eep_rdata = '0;
    logic [CW-1:0] eep_wdata;
    logic          eep_clrb, pgm_eep, read_eep, eep_cycleb, busy, done, fail;

    int tests = 0;
    int fails = 0;

    // Timeline model: offset since acceptance, attempt number, captured word, sticky fail.
    bit          m_active = 1'b0;
    int          m_n = 0;
    int          m_att = 0;
    logic [CW-1:0] m_wdata = '0;
    bit          m_fail = 1'b0;
    int          rd_mode = 0;

    eep_pgm_sequencer #(
        .CACHE_WIDTH(CW), .CLR_CYCLES(CLR), .PGM_CYCLES(PGM),
        .SETTLE_CYCLES(S), .MAX_RETRY(MAXR)
    ) dut (
        .sys_clk(sys_clk), .porb(porb), .pgm_req(pgm_req), .pgm_data(pgm_data),
        .timeoutb(timeoutb), .eep_rdata(eep_rdata), .eep_wdata(eep_wdata),
        .eep_clrb(eep_clrb), .pgm_eep(pgm_eep), .read_eep(read_eep),
        .eep_cycleb(eep_cycleb), .busy(busy), .done(done), .fail(fail)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (!porb) begin
            m_active = 1'b0; m_wdata = '0; m_fail = 1'b0; m_att = 0;
        end else if (!m_active) begin
            if (pgm_req && timeoutb) begin
                m_active = 1'b1; m_n = 0; m_att = 0; m_wdata = pgm_data; m_fail = 1'b0;
            end
        end else if (m_n == T_DONE) begin
            m_active = 1'b0;
        end else if (!timeoutb) begin
            m_n = T_DONE; m_fail = 1'b1;
`ifdef EEP_VERIFY_EN
        end else if (m_n == T_CMP) begin
            if (eep_rdata == m_wdata) m_n = T_DONE;
            else if (m_att < MAXR) begin m_att++; m_n = 0; end
            else begin m_n = T_DONE; m_fail = 1'b1; end
`endif
        end else begin
            m_n++;
        end
    endtask

    function automatic logic [CW+6:0] expect_vec();
        logic clrb, pgm, rd;
        clrb = !(m_active && m_n < CLR);
        pgm  = m_active && (m_n >= CLR + S) && (m_n < CLR + S + PGM);
        rd   = 1'b0;
`ifdef EEP_VERIFY_EN
        rd   = m_active && (m_n == T_SP_END || m_n == T_CMP);
`endif
        return {m_wdata, clrb, pgm, rd, !m_active, m_active, m_active && (m_n == T_DONE), m_fail};
    endfunction

    task automatic tick();
        case (rd_mode)
            1: eep_rdata = (m_att == 0) ? 8'hA4 : 8'hA5;
            2: eep_rdata = 8'h00;
            3: eep_rdata = ($urandom_range(0, 2) == 0) ? (m_wdata ^ 8'h10) : m_wdata;
            default: eep_rdata = m_wdata;
        endcase
        @(posedge sys_clk);
        model_step();
        #1;
        chk("outputs", 32'({eep_wdata, eep_clrb, pgm_eep, read_eep, eep_cycleb, busy, done, fail}),
            32'(expect_vec()));
        chk("strobe_excl", 32'(!eep_clrb && pgm_eep), 32'd0);
    endtask

    task automatic run_to_idle();
        int i;
        i = 0;
        while (m_active && i < 600) begin tick(); i++; end
        if (m_active) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_to_offset(input int n);
        int i;
        i = 0;
        while (m_active && m_n != n && i < 600) begin tick(); i++; end
        chk("reach_offset", 32'(m_n), 32'(n));
    endtask

    initial begin
        int clr_lo, pgm_hi, done_n, done_at, cyc;

        // Reset with request held high
        porb = 1'b0; pgm_req = 1'b1; pgm_data = 8'hFF;
        repeat (3) tick();
        chk("rst_pgm", 32'(pgm_eep), 32'd0);
        chk("rst_clrb", 32'(eep_clrb), 32'd1);

        // Nominal program of A5 with an ignored request during PROGRAM
        porb = 1'b1; pgm_req = 1'b1; pgm_data = 8'hA5;
        tick();
        pgm_req = 1'b0;
        clr_lo = eep_clrb ? 0 : 1; pgm_hi = pgm_eep ? 1 : 0; done_n = 0; done_at = 0; cyc = 0;
        for (int i = 0; i < 300 && m_active; i++) begin
            if (m_n == CLR + S + 5) begin pgm_req = 1'b1; pgm_data = 8'h3C; end
            tick();
            pgm_req = 1'b0;
            cyc++;
            if (!eep_clrb) clr_lo++;
            if (pgm_eep) pgm_hi++;
            if (done) begin done_n++; done_at = cyc; end
        end
        chk("clr_len", 32'(clr_lo), 32'd20);
        chk("pgm_len", 32'(pgm_hi), 32'd40);
        chk("done_count", 32'(done_n), 32'd1);
`ifdef EEP_VERIFY_EN
        chk("done_latency", 32'(done_at), 32'd70);
`else
        chk("done_latency", 32'(done_at), 32'd68);
`endif
        chk("wdata_kept", 32'(eep_wdata), 32'hA5);
        chk("nominal_fail", 32'(fail), 32'd0);

        // Abort in the 10th PROGRAM cycle
        pgm_req = 1'b1; pgm_data = 8'h5A;
        tick();
        pgm_req = 1'b0;
        run_to_offset(CLR + S + 9);
        timeoutb = 1'b0;
        tick();
        timeoutb = 1'b1;
        chk("abort_pgm", 32'(pgm_eep), 32'd0);
        chk("abort_done", 32'(done), 32'd1);
        chk("abort_fail", 32'(fail), 32'd1);
        run_to_idle();
        pgm_req = 1'b1;
        tick();
        pgm_req = 1'b0;
        chk("fail_cleared", 32'(fail), 32'd0);
        run_to_idle();

        // Reset pulse during SETTLE_P, then immediate new request
        pgm_req = 1'b1; pgm_data = 8'hC3;
        tick();
        pgm_req = 1'b0;
        run_to_offset(CLR + S + PGM + 1);
        porb = 1'b0;
        tick();
        porb = 1'b1;
        chk("porb_busy", 32'(busy), 32'd0);
        chk("porb_done", 32'(done), 32'd0);
        chk("porb_wdata", 32'(eep_wdata), 32'd0);
        pgm_req = 1'b1; pgm_data = 8'h96;
        tick();
        pgm_req = 1'b0;
        chk("porb_reaccept", 32'(busy), 32'd1);
        run_to_idle();

`ifdef EEP_VERIFY_EN
        // One mismatch then match, and persistent mismatch
        for (int mode = 1; mode <= 2; mode++) begin
            rd_mode = mode;
            pgm_req = 1'b1; pgm_data = 8'hA5;
            tick();
            pgm_req = 1'b0;
            clr_lo = eep_clrb ? 0 : 1;
            for (int i = 0; i < 900 && m_active; i++) begin
                tick();
                if (!eep_clrb) clr_lo++;
                if (done) chk("verify_fail", 32'(fail), (mode == 1) ? 32'd0 : 32'd1);
            end
            chk("verify_passes", 32'(clr_lo / CLR), (mode == 1) ? 32'd2 : 32'd3);
        end
`endif

        // Random stimulus
        rd_mode = 3;
        for (int i = 0; i < 5000; i++) begin
            porb     = ($urandom_range(0, 299) != 0);
            pgm_req  = ($urandom_range(0, 3) == 0);
            pgm_data = CW'($urandom);
            timeoutb = ($urandom_range(0, 149) != 0);
            tick();
        end
        porb = 1'b1; pgm_req = 1'b0; timeoutb = 1'b1;
        run_to_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
